// File: rtl/mem_bank_ctrl.sv
// Single-port word memory with byte-enabled writes, pipelined reads and a
// one-word-per-cycle background clear sweep.
module mem_bank_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int MEMORY_DEPTH = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic                    clear_done_r;
  logic                    req_ready_s;
  logic                    clear_busy_s;
  logic                    clr_we_s;
  logic                    in_range_s;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic [DATA_WIDTH-1:0]   mem_r [0:MEMORY_DEPTH-1];
  logic [READ_LATENCY-1:0] pv_r;
  logic [READ_LATENCY-1:0] pe_r;
  logic [DATA_WIDTH-1:0]   pd_r [0:READ_LATENCY-1];

  assign in_range_s = ({1'b0, req_addr} < DEPTH_EXT);
  assign wr_en_s    = req_valid && req_ready_s && req_we && in_range_s;
  assign rd_en_s    = req_valid && req_ready_s && !req_we;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear_start is only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_start) state_nxt_s = CLEAR;
        else             state_nxt_s = IDLE;
      end
      CLEAR: begin
        if (cnt_r == LAST_ADDR) state_nxt_s = IDLE;
        else                    state_nxt_s = CLEAR;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs; the sweep write is gated by rst so an aborting edge leaves the word intact
  always_comb begin
    req_ready_s  = (state_r == IDLE) && !rst && !clear_start;
    clear_busy_s = (state_r == CLEAR);
    clr_we_s     = (state_r == CLEAR) && !rst;
  end

  // Sweep address counter and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      clear_done_r <= 1'b0;
    end else begin
      clear_done_r <= (state_r == CLEAR) && (cnt_r == LAST_ADDR);
      if ((state_r == CLEAR) && (cnt_r != LAST_ADDR)) cnt_r <= cnt_r + ADDR_WIDTH'(1);
      else                                             cnt_r <= '0;
    end
  end

  // Memory array; deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[cnt_r[IDX_W-1:0]] <= '0;
    end else if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem_r[req_addr[IDX_W-1:0]][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Read pipeline: data is captured at acceptance, later stages just shift
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd_r[i] <= '0;
    end else begin
      pv_r[0] <= rd_en_s;
      pe_r[0] <= rd_en_s && !in_range_s;
      pd_r[0] <= (rd_en_s && in_range_s) ? mem_r[req_addr[IDX_W-1:0]] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_r[i] <= pv_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign clear_busy = clear_busy_s;
  assign clear_done = clear_done_r;
  assign rsp_valid  = pv_r[READ_LATENCY-1];
  assign rsp_err    = pe_r[READ_LATENCY-1];
  assign rsp_rdata  = pd_r[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl: a latency-1 and a latency-2 instance
// share one stimulus stream; checks are immediate assertions.
module tb_mem_bank_ctrl;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          clear_start;

  logic          a_req_ready, a_rsp_valid, a_rsp_err, a_clear_busy, a_clear_done;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_ready, b_rsp_valid, b_rsp_err, b_clear_busy, b_clear_done;
  logic [DW-1:0] b_rsp_rdata;

  int n_pass = 0;
  int n_total = 0;
  int n_busy;
  int n_done;
  int guard;

  always #5 clk = ~clk;

  mem_bank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .READ_LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .clear_start(clear_start),
    .clear_busy(a_clear_busy), .clear_done(a_clear_done));

  mem_bank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .READ_LATENCY(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .clear_start(clear_start),
    .clear_busy(b_clear_busy), .clear_done(b_clear_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    chk("wr_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e, input string tag);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, a_rsp_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, a_rsp_rdata}, {16'd0, d});
    chk({tag, "_err"}, {31'd0, a_rsp_err}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = 2'b00; clear_start = 1'b0;
    #1;
    chk("ready_in_rst", {31'd0, a_req_ready}, 32'd0);
    tick();
    tick();
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, a_rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, a_clear_busy}, 32'd0);
    chk("rst_done", {31'd0, a_clear_done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_idle", {31'd0, a_req_ready}, 32'd1);

    // basic write/read and byte enables
    do_write(12'd5, 16'h1234, 2'b11);
    do_read(12'd5, 16'h1234, 1'b0, "rd5");
    tick();
    chk("idle_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("idle_rsp_rdata", {16'd0, a_rsp_rdata}, 32'd0);
    do_write(12'd7, 16'h1234, 2'b11);
    do_write(12'd7, 16'hABCD, 2'b01);
    do_read(12'd7, 16'h12CD, 1'b0, "rd7_be01");
    do_write(12'd7, 16'h9900, 2'b10);
    do_read(12'd7, 16'h99CD, 1'b0, "rd7_be10");
    do_write(12'd7, 16'hFFFF, 2'b00);
    do_read(12'd5, 16'h1234, 1'b0, "b2b_first");
    do_read(12'd7, 16'h99CD, 1'b0, "b2b_be00");

    // out of range: no aliasing onto address 2
    do_write(12'd2, 16'h0202, 2'b11);
    do_write(12'd2050, 16'hDEAD, 2'b11);
    do_read(12'd2, 16'h0202, 1'b0, "rd2_no_alias");
    do_read(12'd2048, 16'h0000, 1'b1, "rd_oor2048");
    do_read(12'd2050, 16'h0000, 1'b1, "rd_oor2050");

    // full clear sweep
    do_write(12'd99, 16'h1111, 2'b11);
    do_write(12'd100, 16'h5A5A, 2'b11);
    do_write(12'd2047, 16'h7777, 2'b11);
    clear_start = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd5;
    #1;
    chk("clr_ready_low", {31'd0, a_req_ready}, 32'd0);
    tick();
    clear_start = 1'b0;
    req_valid = 1'b0;
    chk("clr_req_dropped", {31'd0, a_rsp_valid}, 32'd0);
    chk("clr_busy_start", {31'd0, a_clear_busy}, 32'd1);
    n_busy = 0; n_done = 0; guard = 0;
    while (a_clear_busy && guard < 3000) begin
      n_busy++;
      guard++;
      clear_start = (guard == 10);
      tick();
      if (a_clear_done) n_done++;
    end
    clear_start = 1'b0;
    tick();
    if (a_clear_done) n_done++;
    chk("clr_busy_cycles", n_busy, 32'd2048);
    chk("clr_done_pulses", n_done, 32'd1);
    chk("clr_busy_l2", {31'd0, b_clear_busy}, 32'd0);
    do_read(12'd5, 16'h0000, 1'b0, "clr_rd5");
    do_read(12'd100, 16'h0000, 1'b0, "clr_rd100");
    do_read(12'd2047, 16'h0000, 1'b0, "clr_rd2047");

    // reset aborts sweep after addresses 0..99 are zeroed
    do_write(12'd0, 16'h2222, 2'b11);
    do_write(12'd99, 16'h1111, 2'b11);
    do_write(12'd100, 16'h5A5A, 2'b11);
    do_write(12'd101, 16'h6B6B, 2'b11);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (100) tick();
    chk("abort_busy_before", {31'd0, a_clear_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready_rst", {31'd0, a_req_ready}, 32'd0);
    tick();
    chk("abort_busy", {31'd0, a_clear_busy}, 32'd0);
    chk("abort_done", {31'd0, a_clear_done}, 32'd0);
    chk("abort_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    rst = 1'b0;
    do_read(12'd0, 16'h0000, 1'b0, "abort_rd0");
    do_read(12'd99, 16'h0000, 1'b0, "abort_rd99");
    do_read(12'd100, 16'h5A5A, 1'b0, "abort_rd100");
    do_read(12'd101, 16'h6B6B, 1'b0, "abort_rd101");
    tick();
    tick();

    // four consecutive reads, both latencies
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd100;
    tick();
    chk("l2_e0_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("l1_e0_data", {16'd0, a_rsp_rdata}, 32'h5A5A);
    req_addr = 12'd101;
    tick();
    chk("l2_e1_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("l2_e1_data", {16'd0, b_rsp_rdata}, 32'h5A5A);
    chk("l1_e1_data", {16'd0, a_rsp_rdata}, 32'h6B6B);
    req_addr = 12'd99;
    tick();
    chk("l2_e2_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("l2_e2_data", {16'd0, b_rsp_rdata}, 32'h6B6B);
    req_addr = 12'd2048;
    tick();
    req_valid = 1'b0;
    chk("l2_e3_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("l2_e3_data", {16'd0, b_rsp_rdata}, 32'h0000);
    chk("l2_e3_err", {31'd0, b_rsp_err}, 32'd0);
    chk("l1_e3_err", {31'd0, a_rsp_err}, 32'd1);
    tick();
    chk("l2_e4_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("l2_e4_err", {31'd0, b_rsp_err}, 32'd1);
    chk("l1_e4_valid", {31'd0, a_rsp_valid}, 32'd0);
    tick();
    chk("l2_e5_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("l2_e5_err", {31'd0, b_rsp_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bank_ctrl.md
MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous active-high reset: clk (all state updates on rising edge) and rst (synchronous, active-high).
REQ-002 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 11: request address width.
REQ-004 Parameter MEMORY_DEPTH, default 2048: number of words, at most 2^ADDR_WIDTH.
REQ-005 Parameter READ_LATENCY, default 1: read response delay in cycles, legal values 1 or 2.
REQ-006 Ports SHALL be:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables, bit i covers bits [8i+7:8i]
rsp_valid  out  1  one-cycle read response strobe
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  out-of-range flag, qualified by rsp_valid
clear_start  in  1  one-cycle pulse to zero the whole memory
clear_busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse at sweep completion

Function
REQ-007 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-008 req_ready SHALL be combinational: high only in state IDLE, with rst low and clear_start low.
REQ-009 An accepted write with req_addr < MEMORY_DEPTH SHALL update only bytes whose req_be bit is 1, at the accepting edge; other bytes SHALL hold.
REQ-010 An accepted write with req_addr >= MEMORY_DEPTH SHALL be dropped with no memory change and no response.
REQ-011 Writes SHALL produce no rsp_valid.
REQ-012 An accepted read SHALL assert rsp_valid exactly READ_LATENCY cycles after the accepting edge, for one cycle.
REQ-013 Read data SHALL reflect all writes accepted on earlier edges; back-to-back write then read to the same address returns the new data.
REQ-014 An out-of-range read SHALL return rsp_rdata=0 with rsp_err=1; in-range reads SHALL return rsp_err=0.
REQ-015 Reads SHALL be fully pipelined: one accepted per cycle, responses returned in order, with no bubbles.
REQ-016 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.
REQ-017 The FSM SHALL have two states, IDLE and CLEAR.
REQ-018 In IDLE, clear_start=1 SHALL move the FSM to CLEAR with the address counter at 0; clear_start SHALL take priority over a simultaneous req_valid, which is not accepted.
REQ-019 In CLEAR, the FSM SHALL write 0 to one address per cycle, counting 0..MEMORY_DEPTH-1, and hold clear_busy=1.
REQ-020 After address MEMORY_DEPTH-1 is written, the FSM SHALL return to IDLE; clear_done SHALL pulse for one cycle on the first IDLE cycle and clear_busy SHALL drop in that same cycle.
REQ-021 The sweep SHALL last exactly MEMORY_DEPTH cycles.
REQ-022 clear_start SHALL be ignored while in CLEAR.
REQ-023 Reads already in the pipeline when CLEAR begins SHALL complete with the data captured at acceptance.

Reset
REQ-024 While rst=1 at an edge: FSM to IDLE, counter to 0, read pipeline invalidated; after that edge rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_busy=0, clear_done=0.
REQ-025 req_ready SHALL be 0 while rst=1.
REQ-026 Memory contents SHALL NOT be altered by reset.
REQ-027 Reset during CLEAR SHALL abort the sweep; addresses already zeroed stay zeroed and the rest hold old data.

Verification
REQ-028 Write 0x1234 to address 5 (be=11), then read address 5 the next cycle -> rsp_valid one cycle later (READ_LATENCY=1), rsp_rdata=0x1234, rsp_err=0.
REQ-029 Write 0xABCD to address 7 with be=01, then read address 7 -> 0x12CD if the location held 0x1234.
REQ-030 Read address 2048 (DEPTH=2048) -> rsp_rdata=0, rsp_err=1; a write to address 2050 -> no memory change.
REQ-031 Issue clear_start with req_valid high in the same cycle -> request not accepted; clear_busy high for 2048 cycles; clear_done pulses once; a read of any address afterwards returns 0.
REQ-032 Assert rst at sweep cycle 100 -> addresses 0..99 read 0, address 100 onward keep prior data, all outputs 0 after reset.
REQ-033 With READ_LATENCY=2, issue reads on 4 consecutive cycles -> 4 consecutive rsp_valid cycles starting 2 cycles after the first acceptance, in order.
